// File: rtl/obi_regs_arbiter.sv
// Round-robin OBI arbiter: N_REQ masters share one register slave port, responses routed back by ID FIFO.
// Zero added latency on request and response paths; a stalled address phase is locked until granted.

module obi_regs_arbiter_id_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic [CW-1:0] cnt_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_i) wptr_d = ptr_inc(wptr_q);
    if (pop_i)  rptr_d = ptr_inc(rptr_q);
    if (push_i && !pop_i)      cnt_d = cnt_q + 1'b1;
    else if (pop_i && !push_i) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: emptiness is carried entirely by cnt_q.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= data_i;
  end

  assign data_o = mem_q[rptr_q];
  assign cnt_o  = cnt_q;

endmodule

module obi_regs_arbiter #(
  parameter int N_REQ   = 2,
  parameter int MAX_OUT = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N_REQ-1:0]     req_i,
  input  logic [N_REQ-1:0]     we_i,
  input  logic [N_REQ*4-1:0]   be_i,
  input  logic [N_REQ*32-1:0]  addr_i,
  input  logic [N_REQ*32-1:0]  wdata_i,
  output logic [N_REQ-1:0]     gnt_o,
  output logic [N_REQ-1:0]     rvalid_o,
  output logic [N_REQ*32-1:0]  rdata_o,
  output logic                 m_req_o,
  output logic                 m_we_o,
  output logic [3:0]           m_be_o,
  output logic [31:0]          m_addr_o,
  output logic [31:0]          m_wdata_o,
  input  logic                 m_gnt_i,
  input  logic                 m_rvalid_i,
  input  logic [31:0]          m_rdata_i,
  output logic                 err_o
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW  = $clog2(MAX_OUT + 1);

  logic [N_REQ-1:0][3:0]  be_a;
  logic [N_REQ-1:0][31:0] addr_a;
  logic [N_REQ-1:0][31:0] wdata_a;
  logic [N_REQ-1:0][31:0] rdata_a;

  assign be_a    = be_i;
  assign addr_a  = addr_i;
  assign wdata_a = wdata_i;
  assign rdata_o = rdata_a;

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] lsel_q, lsel_d;
  logic           lock_q, lock_d;
  logic           err_q, err_d;

  logic [IDW-1:0] sel_scan, sel, head;
  logic [CW-1:0]  cnt;
  logic           any, m_req, hs, pop, spurious, lock_drop;

  // First asserted request at or after ptr_q, wrapping around.
  always_comb begin
    logic [IDW:0] idx;
    logic         found;
    sel_scan = ptr_q;
    found    = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, ptr_q} + (IDW+1)'(i);
      if (idx >= (IDW+1)'(N_REQ)) idx = idx - (IDW+1)'(N_REQ);
      if (!found && req_i[idx[IDW-1:0]]) begin
        found    = 1'b1;
        sel_scan = idx[IDW-1:0];
      end
    end
  end

  assign sel       = lock_q ? lsel_q : sel_scan;
  assign any       = |req_i;
  assign lock_drop = lock_q & ~req_i[lsel_q];

  // Outputs are held low combinationally while reset is asserted.
  assign m_req    = rst_ni & any & (cnt < CW'(MAX_OUT));
  assign hs       = m_req & m_gnt_i;
  assign pop      = rst_ni & m_rvalid_i & (cnt != '0);
  assign spurious = m_rvalid_i & (cnt == '0);

  assign m_req_o   = m_req;
  assign m_we_o    = m_req & we_i[sel];
  assign m_be_o    = m_req ? be_a[sel]    : '0;
  assign m_addr_o  = m_req ? addr_a[sel]  : '0;
  assign m_wdata_o = m_req ? wdata_a[sel] : '0;

  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    if (hs)  gnt_o[sel]     = 1'b1;
    if (pop) rvalid_o[head] = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      rdata_a[i] = rvalid_o[i] ? m_rdata_i : '0;
    end
  end

  obi_regs_arbiter_id_fifo #(
    .DEPTH (MAX_OUT),
    .W     (IDW),
    .CW    (CW)
  ) u_id_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (hs),
    .data_i (sel),
    .pop_i  (pop),
    .data_o (head),
    .cnt_o  (cnt)
  );

  // A dropped locked request is a protocol violation: unlock and flag it.
  always_comb begin
    ptr_d  = ptr_q;
    lsel_d = lsel_q;
    lock_d = lock_q;
    err_d  = err_q | spurious;
    if (lock_drop) begin
      lock_d = 1'b0;
      err_d  = 1'b1;
    end else if (hs) begin
      lock_d = 1'b0;
    end else if (m_req) begin
      lock_d = 1'b1;
      lsel_d = sel;
    end
    if (hs) ptr_d = (sel == IDW'(N_REQ - 1)) ? '0 : sel + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q  <= '0;
      lsel_q <= '0;
      lock_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      lsel_q <= lsel_d;
      lock_q <= lock_d;
      err_q  <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_obi_regs_arbiter.sv
// Bench for obi_regs_arbiter: vector table, directed corner sequences, then random traffic against a queue model.
module tb_obi_regs_arbiter;
  localparam int N_REQ   = 2;
  localparam int MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, we, gnt, rvalid;
  logic [7:0]  be;
  logic [63:0] addr, wdata, rdata;
  logic        m_req, m_we, m_gnt, m_rvalid, err;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_rdata;

  always #5 clk = ~clk;

  obi_regs_arbiter #(.N_REQ(N_REQ), .MAX_OUT(MAX_OUT)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .we_i       (we),
    .be_i       (be),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .gnt_o      (gnt),
    .rvalid_o   (rvalid),
    .rdata_o    (rdata),
    .m_req_o    (m_req),
    .m_we_o     (m_we),
    .m_be_o     (m_be),
    .m_addr_o   (m_addr),
    .m_wdata_o  (m_wdata),
    .m_gnt_i    (m_gnt),
    .m_rvalid_i (m_rvalid),
    .m_rdata_i  (m_rdata),
    .err_o      (err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] r, input logic g, input logic rv, input logic [31:0] rd);
    req = r; m_gnt = g; m_rvalid = rv; m_rdata = rd;
    #2;
  endtask

  // Fixed payloads in directed phases: port 0 writes 0x1 to 0x4, port 1 reads 0x8.
  task automatic expect_o(input string nm, input logic e_mreq, input logic [1:0] e_gnt,
                          input logic [1:0] e_rv, input logic [31:0] e_addr,
                          input logic [63:0] e_rd, input logic e_err);
    chk({nm, ".m_req"},   64'(m_req),   64'(e_mreq));
    chk({nm, ".gnt"},     64'(gnt),     64'(e_gnt));
    chk({nm, ".rvalid"},  64'(rvalid),  64'(e_rv));
    chk({nm, ".m_addr"},  64'(m_addr),  64'(e_addr));
    chk({nm, ".m_we"},    64'(m_we),    64'(e_addr == 32'h4));
    chk({nm, ".m_wdata"}, 64'(m_wdata), 64'(e_addr >> 2));
    chk({nm, ".m_be"},    64'(m_be),    e_mreq ? 64'hF : 64'h0);
    chk({nm, ".rdata"},   rdata,        e_rd);
    chk({nm, ".err"},     64'(err),     64'(e_err));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  req;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        e_mreq;
    logic [1:0]  e_gnt;
    logic [1:0]  e_rv;
    logic [31:0] e_addr;
    logic [63:0] e_rd;
  } vec_t;

  vec_t tbl[9];

  // Behavioural reference state for the random phase
  int mq[$];
  int m_ptr;
  bit m_lock;
  int m_lsel;
  bit m_err;
  bit [1:0]  pend;
  logic [31:0] pa[2], pw[2];
  logic [3:0]  pb[2];
  logic        pwe[2];

  initial begin
    tbl[0] = '{2'b00, 1'b0, 1'b0, 32'h0,    1'b0, 2'b00, 2'b00, 32'h0, 64'h0};
    tbl[1] = '{2'b01, 1'b1, 1'b0, 32'h0,    1'b1, 2'b01, 2'b00, 32'h4, 64'h0};
    tbl[2] = '{2'b00, 1'b0, 1'b1, 32'hAAAA, 1'b0, 2'b00, 2'b01, 32'h0, 64'h0000_0000_0000_AAAA};
    tbl[3] = '{2'b10, 1'b1, 1'b0, 32'h0,    1'b1, 2'b10, 2'b00, 32'h8, 64'h0};
    tbl[4] = '{2'b00, 1'b0, 1'b1, 32'hBBBB, 1'b0, 2'b00, 2'b10, 32'h0, 64'h0000_BBBB_0000_0000};
    tbl[5] = '{2'b11, 1'b1, 1'b0, 32'h0,    1'b1, 2'b01, 2'b00, 32'h4, 64'h0};
    tbl[6] = '{2'b11, 1'b1, 1'b1, 32'h11,   1'b1, 2'b10, 2'b01, 32'h8, 64'h0000_0000_0000_0011};
    tbl[7] = '{2'b11, 1'b1, 1'b1, 32'h22,   1'b1, 2'b01, 2'b10, 32'h4, 64'h0000_0022_0000_0000};
    tbl[8] = '{2'b00, 1'b0, 1'b1, 32'h33,   1'b0, 2'b00, 2'b01, 32'h0, 64'h0000_0000_0000_0033};

    addr = {32'h8, 32'h4}; wdata = {32'h2, 32'h1}; we = 2'b01; be = 8'hFF;
    rst_n = 1'b0;
    req = '0; m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    @(negedge clk);
    #2;
    expect_o("in_reset", 1'b0, 2'b00, 2'b00, 32'h0, 64'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].req, tbl[i].gnt, tbl[i].rv, tbl[i].rd);
      expect_o($sformatf("vec%0d", i), tbl[i].e_mreq, tbl[i].e_gnt, tbl[i].e_rv,
               tbl[i].e_addr, tbl[i].e_rd, 1'b0);
      tick();
    end

    // Lock: req1 stalls, req0 arrives later but must not steal the address phase
    do_reset();
    drive(2'b10, 1'b0, 1'b0, 32'h0); expect_o("lockA", 1'b1, 2'b00, 2'b00, 32'h8, 64'h0, 1'b0); tick();
    drive(2'b10, 1'b0, 1'b0, 32'h0); expect_o("lockB", 1'b1, 2'b00, 2'b00, 32'h8, 64'h0, 1'b0); tick();
    drive(2'b11, 1'b0, 1'b0, 32'h0); expect_o("lockC", 1'b1, 2'b00, 2'b00, 32'h8, 64'h0, 1'b0); tick();
    drive(2'b11, 1'b1, 1'b0, 32'h0); expect_o("lockD", 1'b1, 2'b10, 2'b00, 32'h8, 64'h0, 1'b0); tick();
    drive(2'b01, 1'b1, 1'b1, 32'h5); expect_o("lockE", 1'b1, 2'b01, 2'b10, 32'h4, 64'h0000_0005_0000_0000, 1'b0); tick();
    drive(2'b00, 1'b0, 1'b1, 32'h6); expect_o("lockF", 1'b0, 2'b00, 2'b01, 32'h0, 64'h6, 1'b0); tick();

    // Outstanding limit
    drive(2'b01, 1'b1, 1'b0, 32'h0); expect_o("out1", 1'b1, 2'b01, 2'b00, 32'h4, 64'h0, 1'b0); tick();
    drive(2'b01, 1'b1, 1'b0, 32'h0); expect_o("out2", 1'b1, 2'b01, 2'b00, 32'h4, 64'h0, 1'b0); tick();
    drive(2'b01, 1'b1, 1'b0, 32'h0); expect_o("out3", 1'b0, 2'b00, 2'b00, 32'h0, 64'h0, 1'b0); tick();
    drive(2'b01, 1'b1, 1'b1, 32'h7); expect_o("out4", 1'b0, 2'b00, 2'b01, 32'h0, 64'h7, 1'b0); tick();
    drive(2'b01, 1'b1, 1'b0, 32'h0); expect_o("out5", 1'b1, 2'b01, 2'b00, 32'h4, 64'h0, 1'b0); tick();
    drive(2'b00, 1'b0, 1'b1, 32'h8); expect_o("out6", 1'b0, 2'b00, 2'b01, 32'h0, 64'h8, 1'b0); tick();
    drive(2'b00, 1'b0, 1'b1, 32'h9); expect_o("out7", 1'b0, 2'b00, 2'b01, 32'h0, 64'h9, 1'b0); tick();

    // Spurious rvalid sets a sticky error
    drive(2'b00, 1'b0, 1'b1, 32'hDEAD); expect_o("spur1", 1'b0, 2'b00, 2'b00, 32'h0, 64'h0, 1'b0); tick();
    drive(2'b00, 1'b0, 1'b0, 32'h0);    expect_o("spur2", 1'b0, 2'b00, 2'b00, 32'h0, 64'h0, 1'b1); tick();
    drive(2'b11, 1'b1, 1'b0, 32'h0);    expect_o("spur3", 1'b1, 2'b10, 2'b00, 32'h8, 64'h0, 1'b1); tick();
    drive(2'b00, 1'b0, 1'b1, 32'h1);    expect_o("spur4", 1'b0, 2'b00, 2'b10, 32'h0, 64'h0000_0001_0000_0000, 1'b1); tick();

    // Async reset with one transaction outstanding
    do_reset();
    drive(2'b01, 1'b1, 1'b0, 32'h0); expect_o("arst1", 1'b1, 2'b01, 2'b00, 32'h4, 64'h0, 1'b0); tick();
    drive(2'b11, 1'b0, 1'b1, 32'h55);
    rst_n = 1'b0;
    #1;
    expect_o("arst2", 1'b0, 2'b00, 2'b00, 32'h0, 64'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b00, 1'b0, 1'b1, 32'h66); expect_o("arst3", 1'b0, 2'b00, 2'b00, 32'h0, 64'h0, 1'b0); tick();
    drive(2'b11, 1'b1, 1'b0, 32'h0);  expect_o("arst4", 1'b1, 2'b01, 2'b00, 32'h4, 64'h0, 1'b1); tick();

    // Random traffic against the reference model
    do_reset();
    mq.delete();
    m_ptr = 0; m_lock = 1'b0; m_lsel = 0; m_err = 1'b0; pend = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int s;
      bit any, e_mreq, e_pop;
      logic [1:0]  e_gnt, e_rv;
      logic [63:0] e_rd;
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i] = 1'b1;
          pa[i] = $urandom; pw[i] = $urandom;
          pb[i] = 4'($urandom_range(15)); pwe[i] = 1'($urandom_range(1));
        end
      end
      req   = pend;
      addr  = {pa[1], pa[0]};
      wdata = {pw[1], pw[0]};
      be    = {pb[1], pb[0]};
      we    = {pwe[1], pwe[0]};
      m_gnt    = 1'($urandom_range(1));
      m_rvalid = (mq.size() > 0) ? 1'($urandom_range(1)) : ($urandom_range(49) == 0);
      m_rdata  = $urandom;
      #2;

      any = (req != 2'b00);
      s = m_ptr;
      if (m_lock) s = m_lsel;
      else begin
        for (int k = N_REQ - 1; k >= 0; k--) begin
          if (req[(m_ptr + k) % N_REQ]) s = (m_ptr + k) % N_REQ;
        end
      end
      e_mreq = any && (mq.size() < MAX_OUT);
      e_gnt = '0;
      if (e_mreq && m_gnt) e_gnt[s] = 1'b1;
      e_pop = m_rvalid && (mq.size() > 0);
      e_rv = '0;
      e_rd = '0;
      if (e_pop) begin
        e_rv[mq[0]] = 1'b1;
        e_rd[mq[0]*32 +: 32] = m_rdata;
      end

      chk("rnd.m_req",   64'(m_req),   64'(e_mreq));
      chk("rnd.gnt",     64'(gnt),     64'(e_gnt));
      chk("rnd.rvalid",  64'(rvalid),  64'(e_rv));
      chk("rnd.rdata",   rdata,        e_rd);
      chk("rnd.m_addr",  64'(m_addr),  e_mreq ? 64'(pa[s])  : 64'h0);
      chk("rnd.m_wdata", 64'(m_wdata), e_mreq ? 64'(pw[s])  : 64'h0);
      chk("rnd.m_be",    64'(m_be),    e_mreq ? 64'(pb[s])  : 64'h0);
      chk("rnd.m_we",    64'(m_we),    e_mreq ? 64'(pwe[s]) : 64'h0);
      chk("rnd.err",     64'(err),     64'(m_err));

      if (e_pop) void'(mq.pop_front());
      else if (m_rvalid) m_err = 1'b1;
      if (m_lock && !req[m_lsel]) begin
        m_lock = 1'b0;
        m_err  = 1'b1;
      end else if (e_gnt != 2'b00) begin
        m_lock = 1'b0;
      end else if (e_mreq) begin
        m_lock = 1'b1;
        m_lsel = s;
      end
      if (e_gnt != 2'b00) begin
        mq.push_back(s);
        m_ptr = (s + 1) % N_REQ;
        pend[s] = 1'b0;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/obi_regs_arbiter.md
# obi_regs_arbiter

Round-robin arbiter that shares one OBI slave register port between `N_REQ` OBI masters, for example the host CPU and the boot/debug sequencer that both program the GPGPU core clock-enable and reset control registers. It forwards one selected request per handshake downstream and keeps the requester's address phase stable until grant. It tracks outstanding transactions in an ID FIFO and routes each response back to the requester that issued it. A sticky error flag reports responses that arrive with no transaction outstanding.

## Interface
- `N_REQ`, 2, number of upstream requesters (≥2)
- `MAX_OUT`, 2, maximum outstanding downstream transactions (ID FIFO depth, ≥1)
- `clk_i`  in  1  clock
- `rst_ni`  in  1  asynchronous, active-low reset
- `req_i`  in  N_REQ  per-requester OBI req
- `we_i`  in  N_REQ  per-requester write enable
- `be_i`  in  N_REQ×4  per-requester byte enables
- `addr_i`  in  N_REQ×32  per-requester address
- `wdata_i`  in  N_REQ×32  per-requester write data
- `gnt_o`  out  N_REQ  per-requester grant
- `rvalid_o`  out  N_REQ  per-requester response valid
- `rdata_o`  out  N_REQ×32  per-requester read data (zero when its rvalid_o is low)
- `m_req_o`, `m_we_o`  out  1  downstream req / we
- `m_be_o`  out  4  downstream byte enables
- `m_addr_o`, `m_wdata_o`  out  32  downstream address / write data
- `m_gnt_i`, `m_rvalid_i`  in  1  downstream grant / response valid
- `m_rdata_i`  in  32  downstream read data
- `err_o`  out  1  sticky protocol error

## Operation
- **State and reset.**
  - State: round-robin pointer `ptr` (0..N_REQ-1), lock flag `lock` with locked index `lsel`, ID FIFO (depth MAX_OUT, entries of clog2(N_REQ) bits), outstanding count `cnt` (0..MAX_OUT), `err`.
  - Reset: `ptr`=0, `lock`=0, `lsel`=0, FIFO empty, `cnt`=0, `err`=0.
  - Every output is 0 during and after reset until a request arrives.
- **Selection.**
  - When `lock`=1: `sel`=`lsel`.
  - When `lock`=0: `sel` is the first asserted `req_i` index found scanning from `ptr` upward with wrap-around.
  - `any` = OR of `req_i`.
- **Forwarding.**
  - `m_req_o` = `any` and `cnt`<MAX_OUT.
  - `m_we_o`, `m_be_o`, `m_addr_o`, `m_wdata_o` are muxed from `sel` and are zero when `m_req_o`=0.
- **Grant.**
  - `gnt_o[sel]` = `m_req_o` & `m_gnt_i`. All other `gnt_o` bits are 0.
- **Handshake** (`m_req_o` & `m_gnt_i`):
  - push `sel` into the FIFO;
  - `ptr` ← (`sel`+1) mod N_REQ;
  - `lock` ← 0.
- **Lock.**
  - If `m_req_o`=1 and `m_gnt_i`=0, then `lock` ← 1 and `lsel` ← `sel`.
  - This holds the downstream address phase stable even if a higher-priority requester asserts later.
  - Requesters must hold `req_i` until granted (OBI rule). If a locked requester drops `req_i` anyway, `lock` clears the next cycle and `err` is set.
- **Response.**
  - On `m_rvalid_i` with `cnt`>0: pop head `h`; `rvalid_o[h]`=1; `rdata_o[h]`=`m_rdata_i`.
  - On `m_rvalid_i` with `cnt`=0: no `rvalid_o` asserted; `err` ← 1.
- **Count.**
  - `cnt` +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - `m_req_o` is gated by registered `cnt`, never by same-cycle `m_rvalid_i`. When full with a pop in the same cycle, no push occurs that cycle.
- **Error flag.** `err_o`=`err`; it clears only on reset.

## Timing
- **Request path.**
  - Combinational from `req_i`/`lock` to `m_req_o` and `gnt_o`.
  - Zero added cycles of request latency.
- **Response path.**
  - Combinational from `m_rvalid_i`/`m_rdata_i` and FIFO head to `rvalid_o`/`rdata_o`.
  - Zero added cycles of response latency.
- **With the core-control register slave** (grant in its idle cycle, rvalid the next cycle):
  - one transaction completes every 2 cycles;
  - `cnt` never exceeds 1.
- **Fairness.** A requester that holds `req_i` continuously is granted within N_REQ handshakes.
- **Reset mid-transaction.** FIFO and `cnt` are cleared immediately and asynchronously. Any late downstream `m_rvalid_i` after reset sets `err`.

## Test plan
- **Single requester write.**
  - Stimulus: req 0 writes addr 0x4, wdata 0x1, be 0xF; slave grants immediately.
  - Response: `m_addr_o`=0x4, `gnt_o`=01, push ID 0; next cycle `rvalid_o`=01, `cnt` returns to 0.
- **Contention.**
  - Stimulus: req 0 and req 1 both assert continuously, `ptr`=0.
  - Response: grants alternate 0,1,0,1; each response is routed to the requester that issued it; `rdata_o` of the non-responding port is 0.
- **Lock.**
  - Stimulus: req 1 asserts alone; `m_gnt_i` held low 3 cycles; req 0 asserts in cycle 2.
  - Response: `m_addr_o` stays at req 1's address until grant; the first grant goes to req 1, the next to req 0.
- **Outstanding limit** (MAX_OUT=2).
  - Stimulus: slave grants every cycle and withholds rvalid.
  - Response: two handshakes occur, then `m_req_o`=0; after one rvalid, `m_req_o` reasserts on the following cycle.
- **Spurious rvalid.**
  - Stimulus: `m_rvalid_i`=1 with `cnt`=0.
  - Response: all `rvalid_o`=0; `err_o`=1 and stays 1 until `rst_ni` is asserted.
- **Async reset mid-transaction.**
  - Stimulus: `rst_ni` asserted while `cnt`=1.
  - Response: all outputs are 0, `cnt`=0, `ptr`=0 before the next clock edge.
